sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
Synchronous request/response front-end for the 128K x 16 asynchronous SRAM model (active-low CE/OE/WE, 17-bit address, 16-bit data). It sits directly upstream of the SRAM. It converts single-beat read/write requests from the processor or stack logic into correctly sequenced chip-select and strobe waveforms with setup, wait and hold phases. It captures read data from stackData and returns it with a valid pulse.

Parameters:
ADDR_W, 17, SRAM address width
DATA_W, 16, SRAM data width
WAIT_CYCLES, 2, number of cycles OE/WE strobe is held low; legal range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: access complete (reads and writes)
rsp_we  out  1  type of the completed access, valid with rsp_valid
rsp_data  out  DATA_W  read data, valid with rsp_valid when rsp_we=0
CE  out  1  SRAM chip enable, active-low
OE  out  1  SRAM output enable, active-low
WE  out  1  SRAM write enable, active-low
address  out  ADDR_W  SRAM address, registered
input_data  out  DATA_W  SRAM write data, registered
stackData  in  DATA_W  SRAM read data

Behaviour:
- Reset (async assert, sync release): state=IDLE; CE=OE=WE=1; address=0; input_data=0; rsp_valid=0; rsp_we=0; rsp_data=0; wait counter=0. req_ready=0 while reset is asserted.
- All outputs are registered; none depends combinationally on req_* inputs. Exception: req_ready = (state==IDLE) && !reset.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: req_ready=1, CE=OE=WE=1. On req_valid && req_ready: latch req_addr into address, req_wdata into input_data (writes only; reads leave input_data unchanged), and req_we into an internal op flag. Go to SETUP.
- SETUP (1 cycle): CE=0, OE=WE=1, address/input_data stable. Counter loads WAIT_CYCLES-1. Go to STROBE.
- STROBE (WAIT_CYCLES cycles): CE=0. WE=0 for writes, or OE=0 for reads; the other strobe stays at 1. Counter decrements each cycle. On the edge where counter==0: for reads, capture stackData into rsp_data; go to HOLD.
- HOLD (1 cycle): CE=0, OE=WE=1, address/input_data still stable (hold time). rsp_valid=1 and rsp_we=op flag. Go to IDLE.
- Latency from the accepting edge E0: SETUP in cycle 1, STROBE in cycles 2..WAIT_CYCLES+1, rsp_valid in cycle WAIT_CYCLES+2, req_ready=1 again in cycle WAIT_CYCLES+3. Maximum throughput is one access per WAIT_CYCLES+3 cycles.
- OE and WE are never low in the same cycle. Neither is ever low while CE=1.
- rsp_data holds its last read value across writes and idle periods.
- Requests arriving while req_ready=0 are ignored. The requester must hold req_valid and its fields until accepted.
- Reset mid-access: strobes and CE return to 1 immediately (async). The in-flight access is dropped with no rsp_valid. A write may be partially committed; this is acceptable.
- WAIT_CYCLES=1 gives a single-cycle strobe. Values outside 1..15 are illegal; the design contains an elaboration-time check.
- Address wrap is not applicable: each access is a single beat, and the address is passed through unmodified.

Decomposition:
- Shared package sram_pkg: state encoding (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3), ADDR_W/DATA_W defaults, and the active-low strobe constants ASSERT_N=1'b0 and DEASSERT_N=1'b1.
- No sub-module. The FSM, the 4-bit wait counter and the output registers form one module. The bench instantiates sram_access_ctrl connected to the existing SRAM model.

Test Plan:
- Reset with reset=1 for 3 cycles -> CE=OE=WE=1, address=0, rsp_valid=0, req_ready=0; req_ready=1 in the first cycle after release.
- Write 0x0001 to 0x00000 (WAIT_CYCLES=2) -> CE low cycles 1-4, WE low cycles 2-3, OE stays high, rsp_valid with rsp_we=1 in cycle 4, req_ready=1 in cycle 5.
- Read 0x00000 after the write -> OE low cycles 2-3, rsp_valid with rsp_we=0 and rsp_data=0x0001 in cycle 4.
- Back-to-back: write 0xBEEF to 0x1FFFF with req_valid held, followed immediately by a read of 0x1FFFF -> the second request is accepted exactly in cycle 5 after the first, and the read returns 0xBEEF.
- req_valid asserted during STROBE with different fields -> ignored; address and input_data unchanged until the next IDLE accept.
- reset pulsed during the STROBE of a read -> CE/OE go high asynchronously, no rsp_valid occurs, and the FSM is in IDLE after release; run once with WAIT_CYCLES=1 and once with WAIT_CYCLES=2.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the synchronous front-end of the 128K x 16 async SRAM.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 16;

  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

endpackage

// File: rtl/sram_access_ctrl.sv
// Turns single-beat read/write requests into CE/OE/WE waveforms with setup, strobe and hold phases.
//
// state  | meaning
// IDLE   | ready for a request, all strobes high
// SETUP  | CE low, address/data settling before the strobe
// STROBE | OE (read) or WE (write) low for WAIT_CYCLES cycles
// HOLD   | strobe released, CE still low, response pulse issued
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_data,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] input_data,
  input  logic [DATA_W-1:0] stackData
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_access_ctrl: WAIT_CYCLES must be within 1..15");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic       op_we;
  logic [3:0] wait_cnt;

  // Only combinational output: lets the requester see readiness without a cycle of lag.
  assign req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_we      <= 1'b0;
      wait_cnt   <= 4'd0;
      CE         <= DEASSERT_N;
      OE         <= DEASSERT_N;
      WE         <= DEASSERT_N;
      address    <= '0;
      input_data <= '0;
      rsp_valid  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            address <= req_addr;
            if (req_we) input_data <= req_wdata;
            op_we <= req_we;
            CE    <= ASSERT_N;
            state <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt <= WAIT_LOAD;
          if (op_we) WE <= ASSERT_N;
          else       OE <= ASSERT_N;
          state <= STROBE;
        end
        STROBE: begin
          // Terminal count: the read data has had the full strobe window to settle.
          if (wait_cnt == 4'd0) begin
            OE        <= DEASSERT_N;
            WE        <= DEASSERT_N;
            rsp_valid <= 1'b1;
            rsp_we    <= op_we;
            if (!op_we) rsp_data <= stackData;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HOLD: begin
          CE    <= DEASSERT_N;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: WAIT_CYCLES=2 instance on a behavioural SRAM, plus a WAIT_CYCLES=1 instance.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset, reset1;
  logic        req_valid, req_ready, req_we;
  logic [16:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_we;
  logic [15:0] rsp_data;
  logic        ce, oe, we_n;
  logic [16:0] address;
  logic [15:0] input_data, stack_data;

  logic        req_valid1, req_ready1, req_we1;
  logic [16:0] req_addr1;
  logic [15:0] req_wdata1;
  logic        rsp_valid1, rsp_we1;
  logic [15:0] rsp_data1;
  logic        ce1, oe1, we1_n;
  logic [16:0] address1;
  logic [15:0] input_data1, stack_data1;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_rd = 16'h0;
  logic [15:0] last_wd = 16'h0;

  logic [15:0] mem [0:131071];

  always #5 clk = ~clk;

  sram_access_ctrl #(.ADDR_W(17), .DATA_W(16), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_data(rsp_data),
    .CE(ce), .OE(oe), .WE(we_n),
    .address(address), .input_data(input_data), .stackData(stack_data)
  );

  sram_access_ctrl #(.ADDR_W(17), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset1),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_we(rsp_we1), .rsp_data(rsp_data1),
    .CE(ce1), .OE(oe1), .WE(we1_n),
    .address(address1), .input_data(input_data1), .stackData(stack_data1)
  );

  // Behavioural async SRAM: write while CE/WE low, read visible while CE/OE low
  always @(posedge clk) if (!ce && !we_n) mem[address] <= input_data;
  assign stack_data  = (!ce && !oe) ? mem[address] : 16'h0000;
  assign stack_data1 = (!ce1 && !oe1) ? ~address1[15:0] : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge in an IDLE cycle; nv/nw/na/nd is presented from cycle 2 on.
  task automatic run_access(input logic w, input logic [16:0] a, input logic [15:0] d,
                            input logic [15:0] exp_rd, input logic nv, input logic nw,
                            input logic [16:0] na, input logic [15:0] nd);
    logic [15:0] exp_in, exp_rsp;
    exp_in  = w ? d : last_wd;
    exp_rsp = w ? last_rd : exp_rd;
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    chk("c0_ready", req_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("c1_ce", ce, 1'b0);
    chk("c1_oe", oe, 1'b1);
    chk("c1_we", we_n, 1'b1);
    chk("c1_addr", address, a);
    chk("c1_wdata", input_data, exp_in);
    chk("c1_ready", req_ready, 1'b0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        req_valid = nv; req_we = nw; req_addr = na; req_wdata = nd;
      end
      chk("strobe_ce", ce, 1'b0);
      chk("strobe_we", we_n, !w);
      chk("strobe_oe", oe, w);
      chk("strobe_addr", address, a);
      chk("strobe_wdata", input_data, exp_in);
      chk("strobe_rsp", rsp_valid, 1'b0);
      chk("strobe_ready", req_ready, 1'b0);
    end
    @(negedge clk);
    chk("hold_ce", ce, 1'b0);
    chk("hold_oe", oe, 1'b1);
    chk("hold_we", we_n, 1'b1);
    chk("hold_addr", address, a);
    chk("hold_rsp_valid", rsp_valid, 1'b1);
    chk("hold_rsp_we", rsp_we, w);
    chk("hold_rsp_data", rsp_data, exp_rsp);
    chk("hold_ready", req_ready, 1'b0);
    @(negedge clk);
    chk("c5_ce", ce, 1'b1);
    chk("c5_rsp_valid", rsp_valid, 1'b0);
    chk("c5_rsp_data", rsp_data, exp_rsp);
    chk("c5_ready", req_ready, 1'b1);
    if (w) last_wd = d;
    else   last_rd = exp_rd;
  endtask

  initial begin
    reset = 1'b1; reset1 = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;

    repeat (3) @(negedge clk);
    chk("rst_ce", ce, 1'b1);
    chk("rst_oe", oe, 1'b1);
    chk("rst_we", we_n, 1'b1);
    chk("rst_addr", address, 17'h0);
    chk("rst_wdata", input_data, 16'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst1_ready", req_ready1, 1'b0);
    chk("rst1_ce", ce1, 1'b1);
    reset = 1'b0; reset1 = 1'b0;
    @(negedge clk);
    chk("rel_ready", req_ready, 1'b1);
    chk("rel1_ready", req_ready1, 1'b1);

    run_access(1'b1, 17'h00000, 16'h0001, 16'h0, 1'b0, 1'b0, 17'h0, 16'h0);
    run_access(1'b0, 17'h00000, 16'hDEAD, 16'h0001, 1'b0, 1'b0, 17'h0, 16'h0);

    // Back-to-back: read presented while the write is still in flight
    run_access(1'b1, 17'h1FFFF, 16'hBEEF, 16'h0, 1'b1, 1'b0, 17'h1FFFF, 16'hC0DE);
    run_access(1'b0, 17'h1FFFF, 16'hC0DE, 16'hBEEF, 1'b0, 1'b0, 17'h0, 16'h0);

    // Differing request offered during STROBE must not disturb the current access
    run_access(1'b1, 17'h00055, 16'h1234, 16'h0, 1'b1, 1'b1, 17'h0AAAA, 16'h5678);
    run_access(1'b1, 17'h0AAAA, 16'h5678, 16'h0, 1'b0, 1'b0, 17'h0, 16'h0);
    run_access(1'b0, 17'h00055, 16'h0000, 16'h1234, 1'b0, 1'b0, 17'h0, 16'h0);
    run_access(1'b0, 17'h0AAAA, 16'h0000, 16'h5678, 1'b0, 1'b0, 17'h0, 16'h0);

    // Reset during a read strobe, WAIT_CYCLES=2
    req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h00055;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_oe_low", oe, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ce", ce, 1'b1);
    chk("mid_rst_oe", oe, 1'b1);
    chk("mid_rst_we", we_n, 1'b1);
    chk("mid_rst_ready", req_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rsp", rsp_valid, 1'b0);
      chk("post_rst_ce", ce, 1'b1);
      chk("post_rst_ready", req_ready, 1'b1);
    end
    chk("post_rst_addr", address, 17'h0);
    last_rd = 16'h0; last_wd = 16'h0;
    run_access(1'b0, 17'h00055, 16'h0000, 16'h1234, 1'b0, 1'b0, 17'h0, 16'h0);

    // WAIT_CYCLES=1: single-cycle strobe read of 0x000F0 returns ~addr
    req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 17'h000F0;
    @(posedge clk); @(negedge clk);
    req_valid1 = 1'b0;
    chk("w1_c1_ce", ce1, 1'b0);
    chk("w1_c1_oe", oe1, 1'b1);
    @(negedge clk);
    chk("w1_c2_oe", oe1, 1'b0);
    chk("w1_c2_we", we1_n, 1'b1);
    @(negedge clk);
    chk("w1_c3_oe", oe1, 1'b1);
    chk("w1_c3_rsp_valid", rsp_valid1, 1'b1);
    chk("w1_c3_rsp_we", rsp_we1, 1'b0);
    chk("w1_c3_rsp_data", rsp_data1, 16'hFF0F);
    @(negedge clk);
    chk("w1_c4_ready", req_ready1, 1'b1);
    chk("w1_c4_ce", ce1, 1'b1);

    // WAIT_CYCLES=1: reset during the strobe
    req_valid1 = 1'b1; req_addr1 = 17'h00033;
    @(posedge clk); @(negedge clk);
    req_valid1 = 1'b0;
    @(negedge clk);
    chk("w1_mid_oe_low", oe1, 1'b0);
    #2 reset1 = 1'b1;
    #1;
    chk("w1_mid_rst_ce", ce1, 1'b1);
    chk("w1_mid_rst_oe", oe1, 1'b1);
    @(negedge clk);
    reset1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w1_post_rst_rsp", rsp_valid1, 1'b0);
      chk("w1_post_rst_ready", req_ready1, 1'b1);
    end
    chk("w1_post_rst_data", rsp_data1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
